// File: rtl/fp32_norm_round_if.sv
// Valid/ready bundle between the FP32 adder front end and the normalize/round back end.
// The slave view belongs to the back end; the master view to whatever feeds and drains it.
interface fp32_norm_round_if #(
  parameter int WIDTH = 24,
  parameter int EXP_W = 10
);
  logic                    in_valid;
  logic                    in_ready;
  logic                    sign;
  logic signed [EXP_W-1:0] exponent;
  logic [WIDTH+3:0]        mant;
  logic [2:0][3:0]         shift_num;
  logic                    out_valid;
  logic                    out_ready;
  logic [31:0]             result;
  logic                    flag_of;
  logic                    flag_uf;
  logic                    flag_nx;

  modport slave (
    input  in_valid, sign, exponent, mant, shift_num, out_ready,
    output in_ready, out_valid, result, flag_of, flag_uf, flag_nx
  );

  modport master (
    output in_valid, sign, exponent, mant, shift_num, out_ready,
    input  in_ready, out_valid, result, flag_of, flag_uf, flag_nx
  );
endinterface

// File: rtl/fp32_norm_round.sv
// FP32 normalize-and-round back end: stage 1 left-normalizes using the LZA shift codes,
// stage 2 rounds to nearest-even and packs the single with overflow/underflow/inexact flags.
module fp32_norm_round #(
  parameter int WIDTH = 24,
  parameter int EXP_W = 10,
  parameter int BIAS  = 127
) (
  input  logic             clk_i,
  input  logic             rst_i,
  fp32_norm_round_if.slave bus
);
  localparam int MW = WIDTH + 4;
  localparam int NW = WIDTH + 3;
  localparam int XW = EXP_W + 1;
  localparam int FW = WIDTH - 1;

  typedef logic signed [XW-1:0] sexp_t;

  localparam sexp_t EXP_MAX = sexp_t'(2 * BIAS + 1);

  function automatic logic [1:0] onehot_idx(input logic [3:0] oh);
    onehot_idx = '0;
    for (int i = 0; i < 4; i++) begin
      if (oh[i]) onehot_idx = 2'(i);
    end
  endfunction

  // Handshake
  logic v1_q, v1_d, v2_q, v2_d;
  logic s1_ready, s2_ready, load1, load2;

  assign s2_ready     = ~v2_q | bus.out_ready;
  assign s1_ready     = ~v1_q | s2_ready;
  assign bus.in_ready = s1_ready;
  assign load1        = bus.in_valid & s1_ready;
  assign load2        = v1_q & s2_ready;
  assign v1_d         = s1_ready ? bus.in_valid : v1_q;
  assign v2_d         = s2_ready ? v1_q : v2_q;

  // Stage 1: normalize
  logic [6:0]    lza_l;
  sexp_t         in_exp, norm_exp;
  logic [NW-1:0] norm_mant;

  assign lza_l  = {1'b0, onehot_idx(bus.shift_num[2]), 4'b0}
                + {3'b0, onehot_idx(bus.shift_num[1]), 2'b0}
                + {5'b0, onehot_idx(bus.shift_num[0])};
  assign in_exp = {bus.exponent[EXP_W-1], bus.exponent};

  // NOTE: blocking assignments in always_comb let later lines see the updated value,
  // which is how the one-bit LZA correction builds on the coarse shift.
  always_comb begin
    norm_mant = '0;
    norm_exp  = in_exp;
    if (bus.mant[MW-1]) begin
      norm_mant = {bus.mant[MW-1:2], bus.mant[1] | bus.mant[0]};
      norm_exp  = in_exp + sexp_t'(1);
    end else begin
      norm_mant = bus.mant[NW-1:0] << lza_l;
      norm_exp  = in_exp - sexp_t'({{(XW-7){1'b0}}, lza_l});
      if (!norm_mant[NW-1] && norm_mant[NW-2]) begin
        norm_mant = norm_mant << 1;
        norm_exp  = norm_exp - sexp_t'(1);
      end
    end
  end

  // The hidden bit is implied after normalization, so only fraction+GRS is kept.
  logic            s1_sign_q, s1_zero_q;
  sexp_t           s1_exp_q;
  logic [NW-2:0]   s1_mant_q;

  // NOTE: payload registers carry no reset; they are qualified by v1_q and only
  // the valid bits need a defined value after reset.
  always_ff @(posedge clk_i) begin
    if (load1) begin
      s1_sign_q <= bus.sign;
      s1_zero_q <= ~|bus.mant;
      s1_exp_q  <= norm_exp;
      s1_mant_q <= norm_mant[NW-2:0];
    end
  end

  // Stage 2: round to nearest-even and pack
  logic [FW-1:0] frac_in, frac_rnd;
  logic          guard_b, round_b, sticky_b, round_up, rnd_carry;
  sexp_t         fin_exp;
  logic [31:0]   result_d, result_q;
  logic          of_d, uf_d, nx_d, of_q, uf_q, nx_q;

  assign frac_in   = s1_mant_q[NW-2:3];
  assign guard_b   = s1_mant_q[2];
  assign round_b   = s1_mant_q[1];
  assign sticky_b  = s1_mant_q[0];
  assign round_up  = guard_b & (round_b | sticky_b | frac_in[0]);
  assign rnd_carry = round_up & (&frac_in);
  assign frac_rnd  = frac_in + FW'(round_up);
  assign fin_exp   = s1_exp_q + sexp_t'({{(XW-1){1'b0}}, rnd_carry});

  always_comb begin
    result_d = {s1_sign_q, fin_exp[7:0], frac_rnd};
    of_d     = 1'b0;
    uf_d     = 1'b0;
    nx_d     = guard_b | round_b | sticky_b;
    if (s1_zero_q) begin
      result_d = '0;
      nx_d     = 1'b0;
    end else if (fin_exp >= EXP_MAX) begin
      result_d = {s1_sign_q, 8'hFF, 23'h0};
      of_d     = 1'b1;
      nx_d     = 1'b1;
    end else if (fin_exp[XW-1] || fin_exp == sexp_t'(0)) begin
      result_d = {s1_sign_q, 31'h0};
      uf_d     = 1'b1;
      nx_d     = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values regardless of block ordering.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      v1_q     <= 1'b0;
      v2_q     <= 1'b0;
      result_q <= '0;
      of_q     <= 1'b0;
      uf_q     <= 1'b0;
      nx_q     <= 1'b0;
    end else begin
      v1_q <= v1_d;
      v2_q <= v2_d;
      if (load2) begin
        result_q <= result_d;
        of_q     <= of_d;
        uf_q     <= uf_d;
        nx_q     <= nx_d;
      end
    end
  end

  assign bus.out_valid = v2_q;
  assign bus.result    = result_q;
  assign bus.flag_of   = of_q;
  assign bus.flag_uf   = uf_q;
  assign bus.flag_nx   = nx_q;
endmodule

// File: tb/tb_fp32_norm_round.sv
// Self-checking bench for fp32_norm_round: integer-arithmetic reference model, scoreboard
// compared on every output handshake, directed vectors with hand-computed literals.
module tb_fp32_norm_round;
  localparam int WIDTH = 24;
  localparam int EXP_W = 10;

  typedef struct packed {
    logic [31:0] result;
    logic [2:0]  fl;      // {of, uf, nx}
  } res_t;

  typedef struct {
    logic        sign;
    int          e;
    logic [27:0] m;
    int          l;
    logic [31:0] res;
    logic [2:0]  fl;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fp32_norm_round_if #(.WIDTH(WIDTH), .EXP_W(EXP_W)) bus ();

  fp32_norm_round #(.WIDTH(WIDTH), .EXP_W(EXP_W), .BIAS(127)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_in     = 0;
  int   n_out    = 0;
  res_t sb_q[$];
  logic held     = 1'b0;
  res_t held_r;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic int oh_idx(input logic [3:0] oh);
    for (int i = 0; i < 4; i++) if (oh[i]) return i;
    return 0;
  endfunction

  function automatic logic [2:0][3:0] enc(input int l);
    logic [2:0][3:0] c;
    c[2] = (l >= 16) ? 4'b0010 : 4'b0001;
    c[1] = 4'b0001 << ((l % 16) / 4);
    c[0] = 4'b0001 << (l % 4);
    return c;
  endfunction

  // Reference: treat the significand as an integer, scale it, round by remainder.
  function automatic res_t model(input logic s, input logic signed [9:0] e_in,
                                 input logic [27:0] mant, input logic [2:0][3:0] sh);
    res_t   r;
    longint m, q, rem;
    int     l, e;
    logic   nx;
    r = '0;
    if (mant == 0) return r;
    l = 16 * oh_idx(sh[2]) + 4 * oh_idx(sh[1]) + oh_idx(sh[0]);
    e = int'(e_in);
    if (mant[27]) begin
      m = (longint'(mant) >> 1) | longint'(mant[0]);
      e = e + 1;
    end else begin
      m = (longint'(mant) << l) % (longint'(1) << 27);
      e = e - l;
      if (m >= (longint'(1) << 25) && m < (longint'(1) << 26)) begin
        m = m * 2;
        e = e - 1;
      end
    end
    q   = m / 8;
    rem = m % 8;
    nx  = (rem != 0);
    if (rem > 4 || (rem == 4 && (q % 2) == 1)) q = q + 1;
    if (q == (longint'(1) << 24)) begin
      q = q / 2;
      e = e + 1;
    end
    if (e >= 255) begin
      r.result = {s, 8'hFF, 23'h0};
      r.fl     = 3'b101;
    end else if (e <= 0) begin
      r.result = {s, 31'h0};
      r.fl     = 3'b011;
    end else begin
      r.result = {s, 8'(e), 23'(q)};
      r.fl     = {2'b00, nx};
    end
    return r;
  endfunction

  // Compare process: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.in_valid)
        assert ($onehot(bus.shift_num[0]) && $onehot(bus.shift_num[1]) && $onehot(bus.shift_num[2]))
          else $error("shift codes not one-hot: %h", bus.shift_num);
      if (bus.out_valid) begin
        if (held) begin
          check("stall_result_stable", bus.result, held_r.result);
          check("stall_flags_stable", 32'({bus.flag_of, bus.flag_uf, bus.flag_nx}), 32'(held_r.fl));
        end
        if (bus.out_ready) begin
          held = 1'b0;
          if (sb_q.size() == 0) begin
            check("unexpected_output", 32'(bus.out_valid), 32'd0);
          end else begin
            res_t ex;
            ex = sb_q.pop_front();
            check("result", bus.result, ex.result);
            check("flags", 32'({bus.flag_of, bus.flag_uf, bus.flag_nx}), 32'(ex.fl));
            n_out++;
          end
        end else begin
          held          = 1'b1;
          held_r.result = bus.result;
          held_r.fl     = {bus.flag_of, bus.flag_uf, bus.flag_nx};
        end
      end else begin
        held = 1'b0;
      end
      if (bus.in_valid && bus.in_ready) begin
        sb_q.push_back(model(bus.sign, bus.exponent, bus.mant, bus.shift_num));
        n_in++;
      end
    end
  end

  task automatic send(input logic s, input int e, input logic [27:0] m, input int l);
    logic acc;
    acc           = 1'b0;
    bus.sign      = s;
    bus.exponent  = 10'(e);
    bus.mant      = m;
    bus.shift_num = enc(l);
    bus.in_valid  = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
      if (acc) break;
    end
    if (!acc) check("accept_timeout", 32'(acc), 32'd1);
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 100; k++) begin
      if (sb_q.size() == 0 && !bus.out_valid) break;
      @(posedge clk);
      #1;
    end
    check("drain_empty", 32'(sb_q.size()), 32'd0);
  endtask

  task automatic expect_latency(input string tag);
    @(negedge clk);
    check({tag, "_lat1"}, 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    check({tag, "_lat2"}, 32'(bus.out_valid), 32'd1);
    @(posedge clk);
    #1;
  endtask

  vec_t dir[$] = '{
    '{1'b0, 127, 28'h4000000,  0, 32'h3F800000, 3'b000},
    '{1'b0, 127, 28'h8000000,  0, 32'h40000000, 3'b000},
    '{1'b0, 127, 28'h0000400, 16, 32'h37800000, 3'b000},
    '{1'b0, 127, 28'h0000200, 16, 32'h37000000, 3'b000},
    '{1'b0, 127, 28'h4000004,  0, 32'h3F800000, 3'b001},
    '{1'b0, 127, 28'h400000C,  0, 32'h3F800002, 3'b001},
    '{1'b0, 127, 28'h7FFFFFC,  0, 32'h40000000, 3'b001},
    '{1'b0, 254, 28'h8000000,  0, 32'h7F800000, 3'b101},
    '{1'b1,   1, 28'h0000400, 16, 32'h80000000, 3'b011},
    '{1'b0, 127, 28'h0000000,  0, 32'h00000000, 3'b000},
    '{1'b1, 127, 28'h0008000, 11, 32'hBA000000, 3'b000},
    '{1'b0, 127, 28'h0004000, 11, 32'h39800000, 3'b000},
    '{1'b0, 127, 28'hC000003,  5, 32'h40400000, 3'b001},
    '{1'b0, 254, 28'h4000000,  0, 32'h7F000000, 3'b000},
    '{1'b0, 254, 28'h7FFFFFC,  0, 32'h7F800000, 3'b101},
    '{1'b0,   1, 28'h4000000,  0, 32'h00800000, 3'b000},
    '{1'b0,   0, 28'h4000000,  0, 32'h00000000, 3'b011}
  };

  logic done_rand = 1'b0;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.sign      = 1'b0;
    bus.exponent  = '0;
    bus.mant      = '0;
    bus.shift_num = enc(0);

    rst = 1'b1;
    #2;
    check("reset_out_valid", 32'(bus.out_valid), 32'd0);
    check("reset_result", bus.result, 32'd0);
    check("reset_flags", 32'({bus.flag_of, bus.flag_uf, bus.flag_nx}), 32'd0);
    check("reset_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Pin the model against hand-computed literals.
    foreach (dir[i]) begin
      res_t r;
      r = model(dir[i].sign, 10'(dir[i].e), dir[i].m, enc(dir[i].l));
      check($sformatf("model_vec%0d_result", i), r.result, dir[i].res);
      check($sformatf("model_vec%0d_flags", i), 32'(r.fl), 32'(dir[i].fl));
    end

    // First beat into an empty pipe: two-cycle latency.
    send(dir[0].sign, dir[0].e, dir[0].m, dir[0].l);
    idle();
    expect_latency("first");
    drain();

    // Directed vectors back to back.
    foreach (dir[i]) send(dir[i].sign, dir[i].e, dir[i].m, dir[i].l);
    idle();
    drain();

    // Stall: four beats with the sink blocked for five cycles.
    bus.out_ready = 1'b0;
    send(1'b0, 127, 28'h4000000, 0);
    send(1'b1, 130, 28'h400000C, 0);
    bus.mant = 28'h0000400;
    bus.shift_num = enc(16);
    @(negedge clk);
    check("stall_in_ready_low", 32'(bus.in_ready), 32'd0);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b1;
    send(1'b0, 127, 28'h0000400, 16);
    send(1'b0, 100, 28'h7FFFFFC, 0);
    idle();
    drain();

    // Random normalized stream with a randomly stalling sink.
    fork
      begin
        for (int n = 0; n < 40; n++) begin
          logic [27:0] m;
          int p, lt, l;
          p  = $urandom_range(3, 26);
          m  = 28'($urandom) & ((28'd1 << p) - 28'd1);
          m[p] = 1'b1;
          lt = 26 - p;
          l  = (lt > 0 && $urandom_range(0, 1) == 1) ? lt - 1 : lt;
          if ($urandom_range(0, 7) == 0) m = 28'($urandom) | 28'h8000000;
          send(1'($urandom), $urandom_range(0, 300), m, l);
        end
        idle();
        done_rand = 1'b1;
      end
      begin
        while (!done_rand) begin
          @(posedge clk);
          #1;
          bus.out_ready = 1'($urandom_range(0, 1));
        end
        bus.out_ready = 1'b1;
      end
    join
    drain();

    // Reset with both stages full: in-flight beats are dropped.
    bus.out_ready = 1'b0;
    send(1'b0, 127, 28'h4000000, 0);
    send(1'b0, 128, 28'h4000000, 0);
    idle();
    @(negedge clk);
    check("pre_reset_full", 32'(bus.in_ready), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    n_in = n_in - sb_q.size();
    sb_q.delete();
    held = 1'b0;
    #1;
    check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    check("midrst_result", bus.result, 32'd0);
    check("midrst_flags", 32'({bus.flag_of, bus.flag_uf, bus.flag_nx}), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.out_ready = 1'b1;
    send(1'b1, 127, 28'h0000200, 16);
    idle();
    expect_latency("post_reset");
    drain();

    check("outputs_equal_inputs", 32'(n_out), 32'(n_in));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
